// File: rtl/k_means_seq_ctrl.sv
// Iteration sequencer for the k-means core: streams the point set from the sample RAM,
// runs the centroid update, checks convergence, and repeats until done.
module k_means_seq_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int ITER_W  = 8,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              abort,
    input  logic [ADDR_W-1:0] num_points,
    input  logic [ITER_W-1:0] max_iter,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              pt_valid,
    output logic              pt_last,
    output logic              acc_clr,
    output logic              upd_start,
    input  logic              upd_done,
    input  logic              changed,
    output logic              busy,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              conv,
    output logic              interupt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RD    = 3'd2,
        S_DRAIN = 3'd3,
        S_UPD   = 3'd4,
        S_CHK   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ITER_W-1:0] ITER_ZERO = {ITER_W{1'b0}};
    localparam logic [ITER_W-1:0] ITER_ONE  = {{(ITER_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [ADDR_W-1:0]   np_r;
    logic [ITER_W-1:0]   mi_r;
    logic                changed_r;
    logic [RAM_LAT-1:0]  vld_pipe_r;
    logic [RAM_LAT-1:0]  last_pipe_r;
    logic [ADDR_W-1:0]   last_addr_s;
    logic                issue_last_s;

    assign last_addr_s  = np_r - ADDR_ONE;
    assign issue_last_s = ram_rd_en && (ram_addr == last_addr_s);
    assign pt_valid     = vld_pipe_r[RAM_LAT-1];
    assign pt_last      = last_pipe_r[RAM_LAT-1];

    // Delay line matching the RAM read latency; abort drops anything in flight
    always_ff @(posedge clk) begin
        if (rst_n || abort) begin
            vld_pipe_r  <= {RAM_LAT{1'b0}};
            last_pipe_r <= {RAM_LAT{1'b0}};
        end else begin
            vld_pipe_r[0]  <= ram_rd_en;
            last_pipe_r[0] <= issue_last_s;
            for (int i = 1; i < RAM_LAT; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                last_pipe_r[i] <= last_pipe_r[i-1];
            end
        end
    end

    // Sequencer state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r   <= S_IDLE;
            np_r      <= ADDR_ZERO;
            mi_r      <= ITER_ZERO;
            changed_r <= 1'b0;
            ram_rd_en <= 1'b0;
            ram_addr  <= ADDR_ZERO;
            acc_clr   <= 1'b0;
            upd_start <= 1'b0;
            busy      <= 1'b0;
            iter_cnt  <= ITER_ZERO;
            conv      <= 1'b0;
            interupt  <= 1'b0;
        end else if (abort) begin
            state_r   <= S_IDLE;
            ram_rd_en <= 1'b0;
            ram_addr  <= ADDR_ZERO;
            acc_clr   <= 1'b0;
            upd_start <= 1'b0;
            busy      <= 1'b0;
            conv      <= 1'b0;
            interupt  <= 1'b0;
        end else begin
            acc_clr   <= 1'b0;
            upd_start <= 1'b0;
            interupt  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // a go coinciding with the completion pulse is dropped
                    if (go && !interupt) begin
                        np_r     <= num_points;
                        mi_r     <= (max_iter == ITER_ZERO) ? ITER_ONE : max_iter;
                        iter_cnt <= ITER_ZERO;
                        conv     <= 1'b0;
                        busy     <= 1'b1;
                        if (num_points != ADDR_ZERO) begin
                            acc_clr <= 1'b1;
                            state_r <= S_CLR;
                        end else begin
                            state_r <= S_DONE;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_CLR: begin
                    ram_addr  <= ADDR_ZERO;
                    ram_rd_en <= 1'b1;
                    state_r   <= S_RD;
                end
                S_RD: begin
                    if (ram_addr == last_addr_s) begin
                        ram_rd_en <= 1'b0;
                        state_r   <= S_DRAIN;
                    end else begin
                        ram_addr <= ram_addr + ADDR_ONE;
                    end
                end
                S_DRAIN: begin
                    if (pt_last) begin
                        upd_start <= 1'b1;
                        state_r   <= S_UPD;
                    end else begin
                        state_r <= S_DRAIN;
                    end
                end
                S_UPD: begin
                    if (upd_done) begin
                        iter_cnt  <= iter_cnt + ITER_ONE;
                        changed_r <= changed;
                        state_r   <= S_CHK;
                    end else begin
                        state_r <= S_UPD;
                    end
                end
                S_CHK: begin
                    if (!changed_r) begin
                        conv    <= 1'b1;
                        state_r <= S_DONE;
                    end else if (iter_cnt == mi_r) begin
                        conv    <= 1'b0;
                        state_r <= S_DONE;
                    end else begin
                        acc_clr <= 1'b1;
                        state_r <= S_CLR;
                    end
                end
                S_DONE: begin
                    interupt <= 1'b1;
                    busy     <= 1'b0;
                    state_r  <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    ram_rd_en <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
